// File: rtl/downcount_timer_ctrl_if.sv
// Control/status bundle between the user-side sequencer and the downcount timer controller.
// The master drives the commands; the slave (the timer) returns count and status.
interface downcount_timer_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] load_val;
   logic             pause;
   logic             abort;
   logic             auto_reload;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             paused;
   logic             done;
   logic [1:0]       state;

   modport master (
      output start, load_val, pause, abort, auto_reload,
      input  count, busy, paused, done, state
   );

   modport slave (
      input  start, load_val, pause, abort, auto_reload,
      output count, busy, paused, done, state
   );
endinterface

// File: rtl/downcount_timer_ctrl.sv
// Sequencing controller for the down-counter datapath: load, decrement, pause/resume, abort,
// terminal-count flag and optional auto-reload. State advances on the falling edge of clk.
module downcount_timer_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  clr_bar,
   downcount_timer_ctrl_if.slave bus
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   logic [1:0]       state_reg;
   logic [1:0]       state_next;
   logic [WIDTH-1:0] count_reg;
   logic [WIDTH-1:0] count_next;

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      case (state_reg)
         ST_IDLE: begin
            // pause outranks start, so a start with pause held is not taken
            if (bus.abort) begin
               count_next = ZERO;
            end else if (!bus.pause && bus.start) begin
               if (bus.load_val != ZERO) begin
                  state_next = ST_RUN;
                  count_next = bus.load_val;
               end else begin
                  state_next = ST_DONE;
                  count_next = ZERO;
               end
            end
         end
         ST_RUN: begin
            if (bus.abort) begin
               state_next = ST_IDLE;
               count_next = ZERO;
            end else if (bus.pause) begin
               state_next = ST_PAUSE;
            end else if (count_reg <= ONE) begin
               // the <= guard keeps a zero count from ever wrapping to all-ones
               state_next = ST_DONE;
               count_next = ZERO;
            end else begin
               count_next = count_reg - ONE;
            end
         end
         ST_PAUSE: begin
            if (bus.abort) begin
               state_next = ST_IDLE;
               count_next = ZERO;
            end else if (!bus.pause) begin
               state_next = ST_RUN;
            end
         end
         ST_DONE: begin
            if (!bus.abort && bus.auto_reload && (bus.load_val != ZERO)) begin
               state_next = ST_RUN;
               count_next = bus.load_val;
            end else begin
               state_next = ST_IDLE;
               count_next = ZERO;
            end
         end
         default: begin
            state_next = ST_IDLE;
            count_next = ZERO;
         end
      endcase
   end

   always_ff @(negedge clk or negedge clr_bar) begin
      if (!clr_bar) begin
         state_reg <= ST_IDLE;
         count_reg <= ZERO;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
      end
   end

   // status is decoded purely from the state register
   assign bus.count  = count_reg;
   assign bus.state  = state_reg;
   assign bus.busy   = (state_reg == ST_RUN) || (state_reg == ST_PAUSE);
   assign bus.paused = (state_reg == ST_PAUSE);
   assign bus.done   = (state_reg == ST_DONE);
endmodule

// File: tb/tb_downcount_timer_ctrl.sv
// Directed and randomized bench for downcount_timer_ctrl against a behavioural model.
module tb_downcount_timer_ctrl;
   localparam int WIDTH = 4;

   logic clk;
   logic clr_bar;
   int   n_total;
   int   n_bad;
   int   n_cyc;

   downcount_timer_ctrl_if #(.WIDTH(WIDTH)) bus ();

   downcount_timer_ctrl #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .clr_bar (clr_bar),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: activity flags plus a remaining-count integer.
   bit m_running;
   bit m_held;
   bit m_finished;
   int m_count;

   task automatic model_reset();
      m_running  = 1'b0;
      m_held     = 1'b0;
      m_finished = 1'b0;
      m_count    = 0;
   endtask

   task automatic model_step();
      int lv;
      lv = int'(bus.load_val);
      if (m_finished) begin
         m_finished = 1'b0;
         if (!bus.abort && bus.auto_reload && lv != 0) begin
            m_running = 1'b1;
            m_count   = lv;
         end
      end else if (m_held) begin
         if (bus.abort) begin
            m_held  = 1'b0;
            m_count = 0;
         end else if (!bus.pause) begin
            m_held    = 1'b0;
            m_running = 1'b1;
         end
      end else if (m_running) begin
         if (bus.abort) begin
            m_running = 1'b0;
            m_count   = 0;
         end else if (bus.pause) begin
            m_running = 1'b0;
            m_held    = 1'b1;
         end else begin
            m_count = m_count - 1;
            if (m_count == 0) begin
               m_running  = 1'b0;
               m_finished = 1'b1;
            end
         end
      end else begin
         if (bus.abort) begin
            m_count = 0;
         end else if (!bus.pause && bus.start) begin
            if (lv != 0) begin
               m_running = 1'b1;
               m_count   = lv;
            end else begin
               m_finished = 1'b1;
               m_count    = 0;
            end
         end
      end
   endtask

   function automatic int exp_state();
      if (m_finished) return 3;
      if (m_held)     return 2;
      if (m_running)  return 1;
      return 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".count"},  32'(bus.count),  32'(m_count));
      chk({tag, ".state"},  32'(bus.state),  32'(exp_state()));
      chk({tag, ".busy"},   32'(bus.busy),   32'(m_running | m_held));
      chk({tag, ".paused"}, 32'(bus.paused), 32'(m_held));
      chk({tag, ".done"},   32'(bus.done),   32'(m_finished));
   endtask

   // One falling (active) edge, then compare on the following rising edge.
   task automatic tick(input string tag);
      @(negedge clk);
      if (clr_bar) model_step();
      else         model_reset();
      @(posedge clk);
      n_cyc++;
      $display("cyc=%0d %s st=%0d cnt=%0d busy=%0b paused=%0b done=%0b",
               n_cyc, tag, bus.state, bus.count, bus.busy, bus.paused, bus.done);
      check_all(tag);
   endtask

   task automatic idle_inputs();
      bus.start       = 1'b0;
      bus.load_val    = '0;
      bus.pause       = 1'b0;
      bus.abort       = 1'b0;
      bus.auto_reload = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      n_total = 0;
      n_bad   = 0;
      n_cyc   = 0;
      clr_bar = 1'b0;
      idle_inputs();
      model_reset();

      // reset held across active edges, even with start asserted
      @(posedge clk);
      check_all("rst");
      bus.start    = 1'b1;
      bus.load_val = 4'd5;
      tick("rst_hold");
      tick("rst_hold");
      idle_inputs();
      clr_bar = 1'b1;
      tick("rst_rel");
      chk("rst_rel_idle", 32'(bus.state), 32'd0);

      // plain countdown from 5
      bus.start = 1'b1; bus.load_val = 4'd5;
      tick("t1_load");
      chk("t1_first", 32'(bus.count), 32'd5);
      idle_inputs();
      for (int i = 0; i < 5; i++) tick("t1_run");
      chk("t1_done", 32'(bus.done), 32'd1);
      tick("t1_end");
      chk("t1_idle", 32'(bus.state), 32'd0);

      // pause at count 3 for four cycles
      bus.start = 1'b1; bus.load_val = 4'd6;
      tick("t2_load");
      idle_inputs();
      for (int i = 0; i < 3; i++) tick("t2_run");
      bus.pause = 1'b1;
      for (int i = 0; i < 4; i++) tick("t2_pause");
      chk("t2_hold", 32'(bus.count), 32'd3);
      bus.pause = 1'b0;
      tick("t2_resume");
      chk("t2_resume_cnt", 32'(bus.count), 32'd3);
      for (int i = 0; i < 4; i++) tick("t2_run");

      // abort beats pause
      bus.start = 1'b1; bus.load_val = 4'd9;
      tick("t3_load");
      idle_inputs();
      for (int i = 0; i < 5; i++) tick("t3_run");
      bus.abort = 1'b1; bus.pause = 1'b1;
      tick("t3_abort");
      chk("t3_abort_done", 32'(bus.done), 32'd0);
      idle_inputs();
      tick("t3_idle");
      bus.start = 1'b1; bus.load_val = 4'd2;
      tick("t3_load2");
      idle_inputs();
      for (int i = 0; i < 3; i++) tick("t3_run2");

      // zero load goes straight to DONE; start during RUN ignored
      bus.start = 1'b1; bus.load_val = 4'd0;
      tick("t4_zero");
      chk("t4_zero_done", 32'(bus.done), 32'd1);
      idle_inputs();
      tick("t4_idle");
      bus.start = 1'b1; bus.load_val = 4'd3;
      tick("t4_load");
      bus.load_val = 4'd15;
      tick("t4_ign");
      chk("t4_ign_cnt", 32'(bus.count), 32'd2);
      idle_inputs();
      for (int i = 0; i < 3; i++) tick("t4_run");

      // periodic auto-reload, then let it drain
      bus.start = 1'b1; bus.load_val = 4'd3; bus.auto_reload = 1'b1;
      tick("t5_load");
      bus.start = 1'b0;
      for (int i = 0; i < 11; i++) tick("t5_auto");
      bus.auto_reload = 1'b0;
      for (int i = 0; i < 5; i++) tick("t5_drain");
      chk("t5_idle", 32'(bus.state), 32'd0);

      // asynchronous clear between edges at count 7
      bus.start = 1'b1; bus.load_val = 4'd15;
      tick("t6_load");
      idle_inputs();
      for (int i = 0; i < 8; i++) tick("t6_run");
      #2;
      clr_bar = 1'b0;
      #1;
      model_reset();
      check_all("t6_async");
      tick("t6_hold");
      clr_bar = 1'b1;
      for (int i = 0; i < 3; i++) tick("t6_after");

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         bus.abort       = ($urandom_range(15) == 0);
         bus.pause       = ($urandom_range(5) == 0);
         bus.start       = !bus.pause && ($urandom_range(3) == 0);
         bus.auto_reload = ($urandom_range(1) == 1);
         bus.load_val    = ($urandom_range(7) == 0) ? 4'd0 : WIDTH'($urandom_range(15));
         tick("rnd");
      end
      idle_inputs();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
